lc3b_mem_responder: RTL and testbench

Memory-side responder for the LC-3b datapath's MIO bus. It accepts word and byte read/write requests driven from MAR/MDR and the control store's MIO.EN, R.W and DATA.SIZE signals. It models a fixed multi-cycle memory latency and returns the ready signal R, which the microsequencer waits on. Storage is a word-organised array with per-byte write enables.

---
 rtl/lc3b_mem_responder_if.sv | 22 ++
 rtl/lc3b_mem_responder.sv | 154 +++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lc3b_mem_responder_if.sv
// MIO bus between the LC-3b datapath (master) and the memory responder (slave).
// Handshake: the master raises MIO_EN with R_W/DATA_SIZE/MAR/MDR and holds MIO_EN until it samples R=1; R is a one-cycle pulse.
interface lc3b_mem_responder_if;
    logic        MIO_EN;
    logic        R_W;
    logic        DATA_SIZE;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] MEM_out;
    logic        R;
    logic        UNALIGNED;

    modport master (
        output MIO_EN, R_W, DATA_SIZE, MAR, MDR,
        input  MEM_out, R, UNALIGNED
    );

    modport slave (
        input  MIO_EN, R_W, DATA_SIZE, MAR, MDR,
        output MEM_out, R, UNALIGNED
    );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency word-organised memory with byte write enables answering LC-3b MIO requests.
// R pulses in cycle LATENCY of a fresh request; back-to-back requests complete every LATENCY+1 cycles.
module lc3b_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 5
) (
    input  logic                 CLK,
    input  logic                 RESET,
    lc3b_mem_responder_if.slave  bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_FRESH = 4'(LATENCY - 2);
    localparam logic [3:0] CNT_TURN  = 4'(LATENCY - 1);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   turn_q, turn_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic                   odd_q, odd_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   rw_q, rw_d;
    logic                   size_q, size_d;
    logic                   r_q, r_d;
    logic                   unal_q, unal_d;
    logic [15:0]            mem_out_q, mem_out_d;

    logic [15:0]            mem [2**ADDR_BITS];

    logic                   do_access;
    logic [ADDR_BITS-1:0]   acc_idx;
    logic                   acc_odd, acc_rw, acc_size;
    logic [15:0]            acc_wdata;
    logic                   we_lo, we_hi;

    logic                   unused_mar_hi;
    assign unused_mar_hi = ^bus.MAR[15:ADDR_BITS+1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        turn_d    = 1'b0;
        idx_d     = idx_q;
        odd_d     = odd_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        size_d    = size_q;
        r_d       = 1'b0;
        unal_d    = 1'b0;
        mem_out_d = mem_out_q;
        do_access = 1'b0;
        acc_idx   = idx_q;
        acc_odd   = odd_q;
        acc_rw    = rw_q;
        acc_size  = size_q;
        acc_wdata = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.MIO_EN) begin
                    idx_d   = bus.MAR[ADDR_BITS:1];
                    odd_d   = bus.MAR[0];
                    wdata_d = bus.MDR;
                    rw_d    = bus.R_W;
                    size_d  = bus.DATA_SIZE;
                    // The idle cycle right after a response is a turnaround cycle, so it adds one to the count.
                    cnt_d   = turn_q ? CNT_TURN : CNT_FRESH;
                    if (!turn_q && LATENCY == 2) begin
                        do_access = 1'b1;
                        acc_idx   = bus.MAR[ADDR_BITS:1];
                        acc_odd   = bus.MAR[0];
                        acc_rw    = bus.R_W;
                        acc_size  = bus.DATA_SIZE;
                        acc_wdata = bus.MDR;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!bus.MIO_EN) begin
                    state_d = IDLE;
                end else if (cnt_q <= 4'd1) begin
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                turn_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            r_d     = 1'b1;
            unal_d  = acc_size & acc_odd;
            if (!acc_rw) mem_out_d = mem[acc_idx];
        end

        // Word writes touch both bytes at the even word; byte writes pick the lane from address bit 0.
        we_lo = do_access & acc_rw & ~RESET & (acc_size | ~acc_odd);
        we_hi = do_access & acc_rw & ~RESET & (acc_size |  acc_odd);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            turn_q    <= 1'b0;
            idx_q     <= '0;
            odd_q     <= 1'b0;
            wdata_q   <= 16'h0000;
            rw_q      <= 1'b0;
            size_q    <= 1'b0;
            r_q       <= 1'b0;
            unal_q    <= 1'b0;
            mem_out_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            turn_q    <= turn_d;
            idx_q     <= idx_d;
            odd_q     <= odd_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            size_q    <= size_d;
            r_q       <= r_d;
            unal_q    <= unal_d;
            mem_out_q <= mem_out_d;
        end
    end

    // Storage is deliberately unreset so it maps onto a plain RAM.
    always_ff @(posedge CLK) begin
        if (we_lo) mem[acc_idx][7:0]  <= acc_wdata[7:0];
        if (we_hi) mem[acc_idx][15:8] <= acc_wdata[15:8];
    end

    assign bus.MEM_out   = mem_out_q;
    assign bus.R         = r_q;
    assign bus.UNALIGNED = unal_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench for lc3b_mem_responder: a LATENCY=5 instance (a) and a LATENCY=2 instance (b).
// Drivers push {R cycle, UNALIGNED, read flag, data} per access; a negedge monitor pops on every R.
module tb_lc3b_mem_responder;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  lc3b_mem_responder_if busa();
  lc3b_mem_responder_if busb();
  logic [1:0] dbg_a, dbg_b;

  lc3b_mem_responder #(.ADDR_BITS(10), .LATENCY(5)) dut_a (
    .CLK(clk), .RESET(rst_a), .bus(busa.slave), .dbg_state(dbg_a)
  );
  lc3b_mem_responder #(.ADDR_BITS(10), .LATENCY(2)) dut_b (
    .CLK(clk), .RESET(rst_b), .bus(busb.slave), .dbg_state(dbg_b)
  );

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [33:0] exp_a[$];
  logic [33:0] exp_b[$];

  task automatic check16(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_bus(int w, logic en, logic rw, logic sz, logic [15:0] mar, logic [15:0] mdr);
    if (w == 0) begin
      busa.MIO_EN = en; busa.R_W = rw; busa.DATA_SIZE = sz; busa.MAR = mar; busa.MDR = mdr;
    end else begin
      busb.MIO_EN = en; busb.R_W = rw; busb.DATA_SIZE = sz; busb.MAR = mar; busb.MDR = mdr;
    end
  endtask

  function automatic logic get_r(int w);
    return (w == 0) ? busa.R : busb.R;
  endfunction

  // Issue n accesses with MIO_EN held high throughout; expected data applies to reads only.
  task automatic req(int w, logic rw, logic sz, logic [15:0] mar, logic [15:0] mdr, int n,
                     logic [15:0] exp_d, logic exp_u);
    int lat;
    int start;
    int got;
    logic [33:0] e;
    lat = (w == 0) ? 5 : 2;
    @(posedge clk); #1;
    set_bus(w, 1'b1, rw, sz, mar, mdr);
    start = int'(cyc);
    for (int k = 0; k < n; k++) begin
      e = {16'(start + lat - 1 + k * (lat + 1)), exp_u, ~rw, exp_d};
      if (w == 0) exp_a.push_back(e);
      else exp_b.push_back(e);
    end
    got = 0;
    for (int t = 0; t < 60 && got < n; t++) begin
      @(negedge clk);
      if (get_r(w)) got++;
    end
    if (got < n) begin
      tests++;
      fails++;
      $display("FAIL r_timeout_%0d: got %0d pulses required %0d (mar %h)", w, got, n, mar);
    end
    @(posedge clk); #1;
    set_bus(w, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  always @(negedge clk) begin
    logic r, u;
    logic [15:0] d;
    logic [33:0] e;
    bit have;
    for (int w = 0; w < 2; w++) begin
      r = (w == 0) ? busa.R : busb.R;
      u = (w == 0) ? busa.UNALIGNED : busb.UNALIGNED;
      d = (w == 0) ? busa.MEM_out : busb.MEM_out;
      if (u && !r) begin
        tests++;
        fails++;
        $display("FAIL unal_without_r_%0d: got 1 required 0 (cycle %0d)", w, cyc);
      end
      if (r) begin
        have = (w == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
        if (!have) begin
          tests++;
          fails++;
          $display("FAIL unexpected_r_%0d: R=1 with nothing outstanding (cycle %0d)", w, cyc);
        end else begin
          e = (w == 0) ? exp_a.pop_front() : exp_b.pop_front();
          check16($sformatf("r_cycle_%0d", w), 16'(cyc), e[33:18]);
          check16($sformatf("unaligned_%0d", w), {15'b0, u}, {15'b0, e[17]});
          if (e[16]) check16($sformatf("mem_out_%0d", w), d, e[15:0]);
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_bus(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check16("reset_r", {15'b0, busa.R}, 16'h0000);
    check16("reset_unal", {15'b0, busa.UNALIGNED}, 16'h0000);
    check16("reset_mem_out", busa.MEM_out, 16'h0000);
    check16("reset_state", {14'b0, dbg_a}, 16'h0000);

    // word write then read-back
    req(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1, 16'h0000, 1'b0);
    req(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1, 16'hBEEF, 1'b0);

    // byte lanes
    req(0, 1'b1, 1'b0, 16'h0020, 16'h1212, 1, 16'h0000, 1'b0);
    req(0, 1'b1, 1'b0, 16'h0021, 16'h3434, 1, 16'h0000, 1'b0);
    check16("write_keeps_mem_out", busa.MEM_out, 16'hBEEF);
    req(0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1, 16'h3412, 1'b0);
    req(0, 1'b1, 1'b0, 16'h0020, 16'hAAAA, 1, 16'h0000, 1'b0);
    req(0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1, 16'h34AA, 1'b0);
    req(0, 1'b0, 1'b0, 16'h0021, 16'h0000, 1, 16'h34AA, 1'b0);

    // unaligned word accesses address the even word
    req(0, 1'b0, 1'b1, 16'h0011, 16'h0000, 1, 16'hBEEF, 1'b1);
    req(0, 1'b1, 1'b1, 16'h0031, 16'h5678, 1, 16'h0000, 1'b1);
    req(0, 1'b0, 1'b1, 16'h0030, 16'h0000, 1, 16'h5678, 1'b0);

    // address bits above the index alias
    req(0, 1'b0, 1'b1, 16'h0810, 16'h0000, 1, 16'hBEEF, 1'b0);

    // aborted write: MIO_EN low in cycle 3
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h1111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (8) @(posedge clk);
    req(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1, 16'hBEEF, 1'b0);

    // reset in cycle 2 of a read
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000);
    @(posedge clk); #1;
    rst_a = 1'b1;
    #1;
    check16("midreset_mem_out", busa.MEM_out, 16'h0000);
    check16("midreset_r", {15'b0, busa.R}, 16'h0000);
    check16("midreset_unal", {15'b0, busa.UNALIGNED}, 16'h0000);
    check16("midreset_state", {14'b0, dbg_a}, 16'h0000);
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst_a = 1'b0;
    req(0, 1'b0, 1'b1, 16'h0030, 16'h0000, 1, 16'h5678, 1'b0);

    // back-to-back reads with MIO_EN held: R every LATENCY+1 cycles
    req(0, 1'b0, 1'b1, 16'h0020, 16'h0000, 2, 16'h34AA, 1'b0);

    // minimum latency instance
    req(1, 1'b1, 1'b1, 16'h0004, 16'hCAFE, 1, 16'h0000, 1'b0);
    req(1, 1'b0, 1'b1, 16'h0004, 16'h0000, 2, 16'hCAFE, 1'b0);
    req(1, 1'b1, 1'b0, 16'h0005, 16'h9999, 1, 16'h0000, 1'b0);
    req(1, 1'b0, 1'b1, 16'h0004, 16'h0000, 1, 16'h99FE, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    check16("queue_a_drained", 16'(exp_a.size()), 16'h0000);
    check16("queue_b_drained", 16'(exp_b.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
